// File: rtl/riscv_mmio_pkg.sv
// Shared definitions for the MMIO controller: register offsets relative to
// MMIO_BASE, the memory-stage load-data select encoding and the UART
// transmit sequencer state encoding.
package riscv_mmio_pkg;

    localparam logic [63:0] OFF_TIMER0  = 64'h00;
    localparam logic [63:0] OFF_TIMER1  = 64'h08;
    localparam logic [63:0] OFF_SW_UP   = 64'h10;
    localparam logic [63:0] OFF_SW_LO   = 64'h18;
    localparam logic [63:0] OFF_BTN1    = 64'h20;
    localparam logic [63:0] OFF_BTN2    = 64'h28;
    localparam logic [63:0] OFF_BTN3    = 64'h30;
    localparam logic [63:0] OFF_UART_TX = 64'h38;

    typedef enum logic [2:0] {
        SEL_DMEM  = 3'd0,
        SEL_TIMER = 3'd1,
        SEL_SW_UP = 3'd2,
        SEL_SW_LO = 3'd3,
        SEL_BTN1  = 3'd4,
        SEL_BTN2  = 3'd5,
        SEL_BTN3  = 3'd6,
        SEL_ZERO  = 3'd7
    } load_sel_e;

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t UART_IDLE = 2'd0;
    localparam uart_state_t UART_SEND = 2'd1;
    localparam uart_state_t UART_WAIT = 2'd2;

endpackage

// File: rtl/riscv_mmio_btn_sync.sv
// Conditioning for one push-button.
//   clk_i, rst_ni : core clock, async active-low reset
//   btn_i         : raw asynchronous button level
//   clr_i         : memory stage is loading this button's register
//   btn_o         : conditioned button value
// Two-flop synchroniser. With RISCV_MMIO_BTN_LATCH_EN defined the output
// is a sticky flag set on a rising edge of the synchronised level and
// cleared by a read (set wins); otherwise it is the synchronised level.
module riscv_mmio_btn_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    input  logic clr_i,
    output logic btn_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
        end
    end

`ifdef RISCV_MMIO_BTN_LATCH_EN
    logic prev_q;
    logic latch_q;
    logic latch_d;

    always_comb begin
        latch_d = latch_q;
        if (clr_i) latch_d = 1'b0;
        // A fresh press must not be lost to a read in the same cycle.
        if (sync_q && !prev_q) latch_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q  <= 1'b0;
            latch_q <= 1'b0;
        end else begin
            prev_q  <= sync_q;
            latch_q <= latch_d;
        end
    end

    assign btn_o = latch_q;
`else
    logic unused_clr;
    assign unused_clr = clr_i;
    assign btn_o      = sync_q;
`endif

endmodule

// File: rtl/riscv_mmio_ctrl.sv
// Memory-mapped I/O controller for the memory stage.
//   i_riscv_mmio_clk/rst_n     : core clock, async active-low reset
//   i_riscv_mmio_addr/load/store/wdata : execute-stage access
//   i_riscv_mmio_btn           : raw buttons, i_riscv_mmio_uart_busy : UART busy
//   o_riscv_mmio_load_mux_sel, o_riscv_mmio_dm_we, o_riscv_mmio_timer_we :
//                                memory-stage register outputs
//   o_riscv_mmio_btn           : conditioned buttons
//   o_riscv_mmio_uart_tx_valid/data : UART send strobe and byte
//   o_riscv_mmio_stall         : hold fetch/decode/execute
// Optional feature macro: RISCV_MMIO_BTN_LATCH_EN (sticky clear-on-read buttons).
//
// UART sequencer states
//   state | meaning
//   IDLE  | no byte in flight
//   SEND  | tx_valid strobe for the captured byte
//   WAIT  | UART store held in execute until busy drops
module riscv_mmio_ctrl
    import riscv_mmio_pkg::*;
#(
    parameter logic [63:0] MMIO_BASE = 64'h0000_0000_0000_2000
) (
    input  logic        i_riscv_mmio_clk,
    input  logic        i_riscv_mmio_rst_n,
    input  logic [63:0] i_riscv_mmio_addr,
    input  logic        i_riscv_mmio_load,
    input  logic        i_riscv_mmio_store,
    input  logic [7:0]  i_riscv_mmio_wdata,
    input  logic [2:0]  i_riscv_mmio_btn,
    input  logic        i_riscv_mmio_uart_busy,
    output logic [2:0]  o_riscv_mmio_load_mux_sel,
    output logic        o_riscv_mmio_dm_we,
    output logic        o_riscv_mmio_timer_we,
    output logic [2:0]  o_riscv_mmio_btn,
    output logic        o_riscv_mmio_uart_tx_valid,
    output logic [7:0]  o_riscv_mmio_uart_tx_data,
    output logic        o_riscv_mmio_stall
);

    logic        is_mmio;
    logic [63:0] offset;
    logic        is_timer;
    logic        is_uart;
    logic        store_only;
    logic        uart_store;
    logic [2:0]  dec_sel;

    assign is_mmio    = (i_riscv_mmio_addr >= MMIO_BASE);
    assign offset     = i_riscv_mmio_addr - MMIO_BASE;
    assign is_timer   = is_mmio && (offset == OFF_TIMER0 || offset == OFF_TIMER1);
    assign is_uart    = is_mmio && (offset == OFF_UART_TX);
    // A simultaneous load wins; the store is dropped.
    assign store_only = i_riscv_mmio_store && !i_riscv_mmio_load;
    assign uart_store = store_only && is_uart;

    always_comb begin
        dec_sel = SEL_DMEM;
        if (is_mmio) begin
            case (offset)
                OFF_TIMER0, OFF_TIMER1: dec_sel = SEL_TIMER;
                OFF_SW_UP:              dec_sel = SEL_SW_UP;
                OFF_SW_LO:              dec_sel = SEL_SW_LO;
                OFF_BTN1:               dec_sel = SEL_BTN1;
                OFF_BTN2:               dec_sel = SEL_BTN2;
                OFF_BTN3:               dec_sel = SEL_BTN3;
                default:                dec_sel = SEL_ZERO;
            endcase
        end
    end

    // UART sequencer
    uart_state_t state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        stall_raw;
    logic        stall;

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        stall_raw = 1'b0;
        case (state_q)
            UART_IDLE: begin
                if (uart_store) begin
                    if (i_riscv_mmio_uart_busy) begin
                        stall_raw = 1'b1;
                        state_d   = UART_WAIT;
                    end else begin
                        tx_data_d = i_riscv_mmio_wdata;
                        state_d   = UART_SEND;
                    end
                end
            end
            UART_SEND: begin
                if (uart_store) begin
                    stall_raw = 1'b1;
                    state_d   = UART_WAIT;
                end else begin
                    state_d = UART_IDLE;
                end
            end
            UART_WAIT: begin
                if (i_riscv_mmio_uart_busy) begin
                    stall_raw = 1'b1;
                end else begin
                    tx_data_d = i_riscv_mmio_wdata;
                    state_d   = UART_SEND;
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    // Reset must release the pipeline immediately even if the held store
    // and busy are still present at the inputs.
    assign stall = stall_raw && i_riscv_mmio_rst_n;

    // Memory-stage register; a stall inserts a bubble.
    logic [2:0] sel_q, sel_d;
    logic       dm_we_q, dm_we_d;
    logic       timer_we_q, timer_we_d;

    assign sel_d      = (!stall && i_riscv_mmio_load) ? dec_sel : SEL_DMEM;
    assign dm_we_d    = !stall && store_only && !is_mmio;
    assign timer_we_d = !stall && store_only && is_timer;

    always_ff @(posedge i_riscv_mmio_clk or negedge i_riscv_mmio_rst_n) begin
        if (!i_riscv_mmio_rst_n) begin
            state_q    <= UART_IDLE;
            tx_data_q  <= 8'h00;
            sel_q      <= SEL_DMEM;
            dm_we_q    <= 1'b0;
            timer_we_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            sel_q      <= sel_d;
            dm_we_q    <= dm_we_d;
            timer_we_q <= timer_we_d;
        end
    end

    // Buttons
    logic [2:0] btn_clr;

    assign btn_clr = {sel_q == SEL_BTN3, sel_q == SEL_BTN2, sel_q == SEL_BTN1};

    for (genvar g = 0; g < 3; g++) begin : g_btn
        riscv_mmio_btn_sync u_btn_sync (
            .clk_i  (i_riscv_mmio_clk),
            .rst_ni (i_riscv_mmio_rst_n),
            .btn_i  (i_riscv_mmio_btn[g]),
            .clr_i  (btn_clr[g]),
            .btn_o  (o_riscv_mmio_btn[g])
        );
    end

    assign o_riscv_mmio_load_mux_sel  = sel_q;
    assign o_riscv_mmio_dm_we         = dm_we_q;
    assign o_riscv_mmio_timer_we      = timer_we_q;
    assign o_riscv_mmio_uart_tx_valid = (state_q == UART_SEND);
    assign o_riscv_mmio_uart_tx_data  = tx_data_q;
    assign o_riscv_mmio_stall         = stall;

endmodule
